// File: rtl/beq_hazard_stall.sv
// BEQ hazard unit for a 5-stage pipeline with branch resolution in ID.
// A BEQ reads its operands in ID. A load still in EX costs two stall cycles
// and a load in MEM costs one. A taken BEQ squashes the IF/ID slot once.
// ALU producers need no stall because BEQ forwarding covers them.
module beq_hazard_stall (
   input  logic        clk,
   input  logic        rst,
   input  logic [0:7]  Control,
   input  logic [4:0]  IDRs,
   input  logic [4:0]  IDRt,
   input  logic [4:0]  EXRd,
   input  logic [4:0]  MEMRd,
   input  logic        EXMemRead,
   input  logic        MEMMemRead,
   input  logic        BranchTaken,
   output logic        PCWrite,
   output logic        IFIDWrite,
   output logic        CtrlBubble,
   output logic        IFFlush,
   output logic [15:0] StallCount,
   output logic [1:0]  HazState
);

   typedef enum logic [1:0] {
      StIdle   = 2'b00,
      StLdWait = 2'b01,
      StFlush  = 2'b10
   } haz_state_e;

   localparam logic [7:0] BeqCtrl = 8'b00001000;

   haz_state_e state_q, state_d;

   logic is_beq;
   logic match_ex;
   logic match_mem;
   logic load_ex_haz;
   logic load_mem_haz;
   logic stall;
   logic flush;

   // Hazard decode. Rs == Rt on the same producer is still one match.
   always_comb begin
      is_beq       = (Control == BeqCtrl);
      match_ex     = (EXRd != 5'd0) && ((EXRd == IDRs) || (EXRd == IDRt));
      match_mem    = (MEMRd != 5'd0) && ((MEMRd == IDRs) || (MEMRd == IDRt));
      load_ex_haz  = is_beq && EXMemRead && match_ex;
      load_mem_haz = is_beq && MEMMemRead && match_mem;
   end

   // Next state, stall and flush. A stall always wins over BranchTaken.
   always_comb begin
      state_d = StIdle;
      stall   = 1'b0;
      flush   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (load_ex_haz) begin
               // The load value is two stages away: hold here, then once more.
               stall   = 1'b1;
               state_d = StLdWait;
            end else if (load_mem_haz) begin
               // One cycle later the value reaches WB and is forwardable.
               stall   = 1'b1;
               state_d = StIdle;
            end else if (is_beq && BranchTaken) begin
               flush   = 1'b1;
               state_d = StFlush;
            end else begin
               state_d = StIdle;
            end
         end
         StLdWait: begin
            // Second stall cycle of a load-in-EX hazard, inputs ignored.
            stall   = 1'b1;
            state_d = StIdle;
         end
         StFlush: begin
            // The slot in ID is the squashed instruction, never a real BEQ.
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      // Reset releases the pipeline even if hazard inputs are present.
      if (rst) begin
         stall = 1'b0;
         flush = 1'b0;
      end
   end

   // Pipeline control outputs follow directly from stall and flush.
   always_comb begin
      PCWrite    = ~stall;
      IFIDWrite  = ~stall;
      CtrlBubble = stall;
      IFFlush    = flush;
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Saturating count of stalled cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         StallCount <= 16'd0;
      end else if (stall && (StallCount != 16'hFFFF)) begin
         StallCount <= StallCount + 16'd1;
      end
   end

   assign HazState = state_q;

endmodule

// File: tb/tb_beq_hazard_stall.sv
// Bench for beq_hazard_stall: directed scenarios plus random traffic, all
// checked against a model that tracks remaining forced stalls and a squash flag.
module tb_beq_hazard_stall;

   logic        clk;
   logic        rst;
   logic [0:7]  Control;
   logic [4:0]  IDRs, IDRt, EXRd, MEMRd;
   logic        EXMemRead, MEMMemRead, BranchTaken;
   logic        PCWrite, IFIDWrite, CtrlBubble, IFFlush;
   logic [15:0] StallCount;
   logic [1:0]  HazState;

   int total = 0;
   int bad   = 0;

   beq_hazard_stall dut (
      .clk        (clk),
      .rst        (rst),
      .Control    (Control),
      .IDRs       (IDRs),
      .IDRt       (IDRt),
      .EXRd       (EXRd),
      .MEMRd      (MEMRd),
      .EXMemRead  (EXMemRead),
      .MEMMemRead (MEMMemRead),
      .BranchTaken(BranchTaken),
      .PCWrite    (PCWrite),
      .IFIDWrite  (IFIDWrite),
      .CtrlBubble (CtrlBubble),
      .IFFlush    (IFFlush),
      .StallCount (StallCount),
      .HazState   (HazState)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: stall_left = forced stall cycles still owed, squash = slot in ID is dead.
   int stall_left;
   bit squash;
   int cnt;
   bit exp_stall, exp_flush;
   logic [1:0] exp_state;

   always_comb begin
      bit beq, mex, mmem;
      beq  = (Control == 8'b00001000);
      mex  = (EXRd != 0) && (EXRd == IDRs || EXRd == IDRt);
      mmem = (MEMRd != 0) && (MEMRd == IDRs || MEMRd == IDRt);
      exp_stall = 1'b0;
      exp_flush = 1'b0;
      exp_state = (stall_left > 0) ? 2'b01 : (squash ? 2'b10 : 2'b00);
      if (!rst) begin
         if (stall_left > 0) exp_stall = 1'b1;
         else if (!squash && beq) begin
            if ((EXMemRead && mex) || (MEMMemRead && mmem)) exp_stall = 1'b1;
            else if (BranchTaken) exp_flush = 1'b1;
         end
      end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_left <= 0;
         squash     <= 1'b0;
         cnt        <= 0;
      end else begin
         cnt <= cnt + (exp_stall ? 1 : 0);
         if (stall_left > 0) stall_left <= stall_left - 1;
         else if (exp_stall && EXMemRead && (EXRd != 0) && (EXRd == IDRs || EXRd == IDRt))
            stall_left <= 1;
         squash <= exp_flush;
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
      end
   endtask

   // Per-cycle compare against the model, away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         chk("model_ctrl", {PCWrite, IFIDWrite, CtrlBubble, IFFlush},
             {~exp_stall, ~exp_stall, exp_stall, exp_flush});
         chk("model_state", HazState, exp_state);
         chk("model_count", StallCount, (cnt > 65535) ? 65535 : cnt);
      end
   end

   task automatic drv(input bit beq, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] exrd, input bit exmr, input logic [4:0] memrd,
                      input bit memmr, input bit bt);
      Control     = beq ? 8'b00001000 : 8'b00000000;
      IDRs        = rs;
      IDRt        = rt;
      EXRd        = exrd;
      EXMemRead   = exmr;
      MEMRd       = memrd;
      MEMMemRead  = memmr;
      BranchTaken = bt;
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      nxt();
      rst = 1'b1;
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("rst_ctrl", {PCWrite, IFIDWrite, CtrlBubble, IFFlush}, 4'b1100);
      chk("rst_state", HazState, 2'b00);
      chk("rst_count", StallCount, 0);
      #12;
      rst = 1'b0;

      // V1: load in EX feeding BEQ $2,$3 -> two stall cycles.
      nxt();
      drv(1, 2, 3, 2, 1, 0, 0, 0);
      #1;
      chk("v1_stall1", {PCWrite, IFIDWrite, CtrlBubble}, 3'b001);
      chk("v1_state0", HazState, 2'b00);
      nxt();
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("v1_stall2", PCWrite, 0);
      chk("v1_state1", HazState, 2'b01);
      nxt();
      chk("v1_release", PCWrite, 1);
      chk("v1_count", StallCount, 2);

      // V2: load in MEM feeding BEQ $4,$5 -> one stall cycle.
      do_reset();
      nxt();
      drv(1, 4, 5, 0, 0, 5, 1, 0);
      #1;
      chk("v2_stall", PCWrite, 0);
      nxt();
      drv(1, 4, 5, 0, 0, 0, 0, 0);
      #1;
      chk("v2_release", PCWrite, 1);
      chk("v2_state", HazState, 2'b00);
      chk("v2_count", StallCount, 1);

      // V3/V4: $0 never hazards; taken BEQ flushes once, then FLUSH slot.
      do_reset();
      nxt();
      drv(1, 0, 0, 0, 1, 0, 1, 1);
      #1;
      chk("v3_nostall", PCWrite, 1);
      chk("v3_flush", IFFlush, 1);
      nxt();
      drv(1, 1, 2, 0, 0, 0, 0, 1);
      #1;
      chk("v4_state", HazState, 2'b10);
      chk("v4_noflush", IFFlush, 0);
      nxt();
      drv(1, 0, 0, 0, 1, 0, 0, 0);
      #1;
      chk("v3_nottaken", IFFlush, 0);
      chk("v3_count", StallCount, 0);

      // V7: load hazard and taken branch together -> stall, no flush.
      nxt();
      drv(1, 6, 7, 6, 1, 0, 0, 1);
      #1;
      chk("v7_stall", PCWrite, 0);
      chk("v7_noflush", IFFlush, 0);

      // V5: reset in the middle of LDWAIT, hazard inputs still present.
      do_reset();
      nxt();
      drv(1, 2, 3, 2, 1, 0, 0, 0);
      nxt();
      #1;
      rst = 1'b1;
      #1;
      chk("v5_state", HazState, 2'b00);
      chk("v5_ctrl", {PCWrite, IFIDWrite, CtrlBubble, IFFlush}, 4'b1100);
      chk("v5_count", StallCount, 0);
      rst = 1'b0;
      drv(0, 0, 0, 0, 0, 0, 0, 0);

      // Random traffic with small register numbers to provoke matches.
      for (int i = 0; i < 3000; i++) begin
         nxt();
         drv($urandom_range(0, 2) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
             1'($urandom));
         if ($urandom_range(0, 3) == 0) Control = 8'($urandom);
         if ($urandom_range(0, 99) == 0) begin
            #1;
            rst = 1'b1;
            #1;
            chk("rnd_rst_ctrl", {PCWrite, IFIDWrite, CtrlBubble, IFFlush}, 4'b1100);
            rst = 1'b0;
         end
      end

      // V6: continuous load-in-EX hazard saturates the counter.
      do_reset();
      nxt();
      drv(1, 2, 3, 3, 1, 0, 0, 0);
      repeat (65540) @(posedge clk);
      #1;
      chk("v6_sat", StallCount, 16'hFFFF);
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      nxt();
      nxt();
      chk("v6_hold", StallCount, 16'hFFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/beq_hazard_stall.md
BEQ_HAZARD_STALL -- requirements
Module: beq_hazard_stall

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named as the codebase does.
REQ-002 Port list, one per line: name  direction  width  meaning.
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous active-high reset
- Control  in  [0:7]  ID-stage control word; 8'b00001000 means BEQ
- IDRs, IDRt  in  5  BEQ source registers in ID
- EXRd, MEMRd  in  5  destination registers in EX and MEM
- EXMemRead, MEMMemRead  in  1  load flag in EX and MEM
- BranchTaken  in  1  ID-stage compare result for the forwarded operands
- PCWrite  out  1  1 = PC may update
- IFIDWrite  out  1  1 = IF/ID may update
- CtrlBubble  out  1  1 = zero the ID/EX control
- IFFlush  out  1  1 = squash the IF/ID instruction
- StallCount  out  16  saturating count of BEQ stall cycles
- HazState  out  2  FSM state, for debug

Function
REQ-003 Define isBEQ = (Control == 8'b00001000).
REQ-004 Define matchEX = EXRd != 0 and (EXRd == IDRs or EXRd == IDRt).
REQ-005 Define matchMEM = MEMRd != 0 and (MEMRd == IDRs or MEMRd == IDRt).
REQ-006 The FSM SHALL have the states IDLE = 2'b00, LDWAIT = 2'b01 and FLUSH = 2'b10, and HazState SHALL show the current state.
REQ-007 In IDLE with isBEQ, EXMemRead and matchEX (load in EX):
- stall this cycle: PCWrite = 0, IFIDWrite = 0, CtrlBubble = 1
- next state = LDWAIT
REQ-008 In IDLE with isBEQ, MEMMemRead and matchMEM (load in MEM), and REQ-007 not met:
- stall this cycle
- next state = IDLE, so the BEQ is re-evaluated the next cycle
REQ-009 In LDWAIT:
- stall unconditionally, ignoring all inputs
- next state = IDLE, so a load-in-EX hazard always costs exactly 2 stall cycles
REQ-010 In IDLE with isBEQ, no stall condition and BranchTaken = 1:
- PCWrite = 1, IFIDWrite = 1, CtrlBubble = 0, IFFlush = 1 for this cycle
- next state = FLUSH
REQ-011 In FLUSH:
- IFFlush = 0, no stall
- isBEQ is ignored (the squashed slot) and the state returns to IDLE
- a second taken BEQ cannot flush twice in a row
REQ-012 When isBEQ is 0 in IDLE, the outputs SHALL be PCWrite = 1, IFIDWrite = 1, CtrlBubble = 0 and IFFlush = 0.
REQ-013 Non-load (ALU) hazards on EXRd or MEMRd SHALL NOT stall; they are resolved by BEQ forwarding.
REQ-014 BranchTaken SHALL be ignored in any cycle in which a stall is asserted.
REQ-015 PCWrite, IFIDWrite, CtrlBubble and IFFlush SHALL be combinational functions of the state and inputs, valid in the same cycle with no added latency.
REQ-016 StallCount SHALL increment on each rising edge where PCWrite == 0, and SHALL saturate at 16'hFFFF with no wrap.
REQ-017 IDRs == IDRt == a matching register SHALL count as one hazard, not two.
REQ-018 All register writes SHALL use nonblocking assignment, and the combinational outputs SHALL have a default for every path (no latches).

Reset
REQ-019 While rst = 1:
- state = IDLE, StallCount = 0
- PCWrite = 1, IFIDWrite = 1, CtrlBubble = 0, IFFlush = 0
REQ-020 Reset asserted in LDWAIT or FLUSH SHALL return the FSM to IDLE at once, asynchronously, with no leftover stall or flush.
REQ-021 After rst deasserts, the first rising edge SHALL evaluate hazards normally.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- V1: BEQ $2,$3 in ID, EXMemRead = 1, EXRd = 2 -> PCWrite = 0 for exactly 2 cycles (IDLE->LDWAIT->IDLE), StallCount 0->2.
- V2: BEQ $4,$5 in ID, MEMMemRead = 1, MEMRd = 5, EX clear -> 1 stall cycle, then PCWrite = 1, StallCount = 1.
- V3: BEQ $0,$0 with EXRd = 0, EXMemRead = 1 -> no stall, and IFFlush follows BranchTaken.
- V4: BEQ with no hazard, BranchTaken = 1 -> IFFlush = 1 for one cycle, state FLUSH; a BEQ in the following cycle -> IFFlush = 0.
- V5: rst pulsed in the middle of LDWAIT -> HazState = 00 and PCWrite = 1 immediately, StallCount = 0.
- V6: 65540 back-to-back load-in-EX hazards -> StallCount holds at 16'hFFFF.
- V7: BEQ $6,$7, EXMemRead = 1, EXRd = 6 and BranchTaken = 1 simultaneously -> stall, IFFlush = 0.
